// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM states, write-enable
// constant, default size limit and the word-address helper.
package inst_loader_pkg;

  // Loader FSM states. HDR_ADDR is the reset state.
  typedef enum logic [2:0] {
    HDR_ADDR = 3'd0,
    HDR_CNT  = 3'd1,
    DATA     = 3'd2,
    WRITE    = 3'd3,
    VFY_REQ  = 3'd4,
    VFY_WAIT = 3'd5,
    DONE     = 3'd6,
    ERROR    = 3'd7
  } state_t;

  // All four byte lanes enabled for a full 32-bit write.
  localparam logic [3:0] WE_FULL = 4'hF;

  // Largest word count accepted by default.
  localparam int unsigned MAX_WORDS_DEFAULT = 4096;

  // Byte address of word idx relative to base; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Collects four accepted bytes into a little-endian 32-bit word.
// The first byte lands in bits 7:0. word_valid_o pulses combinationally
// in the cycle the 4th byte is accepted, with word_o holding the full word.
module byte_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  // Only the first three bytes need storage; the fourth arrives on byte_i.
  logic [23:0] shift_q, shift_d;

  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

  // Next byte count and shift contents; clear has priority over a byte.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = 2'd0;
      shift_d = 24'h0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_i, shift_q[23:8]};
    end
  end

  // Byte counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'h0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: parses a byte stream (base address, word count,
// words), writes the words into the instruction cache debug port, reads
// them back, compares checksums, and releases the core from reset only
// when the readback matches.
//
// Byte handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both high; in_valid without in_ready leaves the byte
// pending and the source must hold it.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS  = MAX_WORDS_DEFAULT,
  parameter int unsigned RD_LATENCY = 1   // 1..256
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        restart,
  output logic [31:0] CPU_Debug_InstCache_A2,
  output logic [31:0] CPU_Debug_InstCache_WD2,
  output logic [3:0]  CPU_Debug_InstCache_WE2,
  input  logic [31:0] CPU_Debug_InstCache_RD2,
  output logic        core_rst,
  output logic        load_pass,
  output logic        load_err,
  output state_t      dbg_state,
  output logic [31:0] dbg_wr_sum
);

  localparam logic [7:0]  LAT_LAST  = 8'(RD_LATENCY - 1);
  localparam logic [31:0] MAX_COUNT = 32'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [31:0] base_q,  base_d;
  logic [31:0] n_q,     n_d;
  logic [31:0] idx_q,   idx_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wd_q,    wd_d;
  logic [31:0] wsum_q,  wsum_d;
  logic [31:0] rsum_q,  rsum_d;
  logic [7:0]  lat_q,   lat_d;

  logic        byte_take;
  logic        restart_ok;
  logic [31:0] word;
  logic        word_valid;
  logic [31:0] idx_next;
  logic        more_words;
  logic [31:0] rsum_next;

  // Only the header and data states consume bytes.
  assign in_ready   = (state_q == HDR_ADDR) || (state_q == HDR_CNT) ||
                      (state_q == DATA);
  assign byte_take  = in_valid && in_ready;
  assign restart_ok = restart && ((state_q == DONE) || (state_q == ERROR));

  assign idx_next   = idx_q + 32'd1;
  assign more_words = idx_next < n_q;
  assign rsum_next  = rsum_q + CPU_Debug_InstCache_RD2;

  byte_assembler u_asm (
    .clk          (CPU_CLK),
    .rst_n        (CPU_RST_N),
    .clear_i      (restart_ok),
    .byte_valid_i (byte_take),
    .byte_i       (in_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Cache port: address and data come straight from registers so they stay
  // stable between accesses; the write strobe is decoded from the state.
  assign CPU_Debug_InstCache_A2  = addr_q;
  assign CPU_Debug_InstCache_WD2 = wd_q;
  assign CPU_Debug_InstCache_WE2 = (state_q == WRITE) ? WE_FULL : 4'h0;

  assign core_rst   = (state_q != DONE);
  assign load_pass  = (state_q == DONE);
  assign load_err   = (state_q == ERROR);
  assign dbg_state  = state_q;
  assign dbg_wr_sum = wsum_q;

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    n_d     = n_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    wsum_d  = wsum_q;
    rsum_d  = rsum_q;
    lat_d   = lat_q;

    unique case (state_q)
      HDR_ADDR: begin
        if (word_valid) begin
          base_d  = word;
          state_d = (word[1:0] != 2'b00) ? ERROR : HDR_CNT;
        end
      end

      HDR_CNT: begin
        if (word_valid) begin
          n_d   = word;
          idx_d = 32'd0;
          if (word > MAX_COUNT)   state_d = ERROR;
          else if (word == 32'd0) state_d = DONE;
          else                    state_d = DATA;
        end
      end

      DATA: begin
        if (word_valid) begin
          wd_d    = word;
          addr_d  = word_addr(base_q, idx_q);
          state_d = WRITE;
        end
      end

      // One-cycle write strobe; fold the word into the write checksum.
      WRITE: begin
        wsum_d = wsum_q + wd_q;
        if (more_words) begin
          idx_d   = idx_next;
          state_d = DATA;
        end else begin
          idx_d   = 32'd0;
          addr_d  = base_q;
          state_d = VFY_REQ;
        end
      end

      VFY_REQ: begin
        lat_d   = 8'd0;
        state_d = VFY_WAIT;
      end

      // Hold the address until the read data is due, then accumulate it.
      VFY_WAIT: begin
        if (lat_q == LAT_LAST) begin
          rsum_d = rsum_next;
          if (more_words) begin
            idx_d   = idx_next;
            addr_d  = word_addr(base_q, idx_next);
            state_d = VFY_REQ;
          end else begin
            state_d = (rsum_next == wsum_q) ? DONE : ERROR;
          end
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end

      DONE, ERROR: begin
        if (restart_ok) begin
          state_d = HDR_ADDR;
          base_d  = 32'd0;
          n_d     = 32'd0;
          idx_d   = 32'd0;
          wsum_d  = 32'd0;
          rsum_d  = 32'd0;
          lat_d   = 8'd0;
        end
      end

      default: state_d = HDR_ADDR;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q <= HDR_ADDR;
      base_q  <= 32'd0;
      n_q     <= 32'd0;
      idx_q   <= 32'd0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      wsum_q  <= 32'd0;
      rsum_q  <= 32'd0;
      lat_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
      lat_q   <= lat_d;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: random byte streams, a behavioural cache with
// configurable read latency and optional readback corruption, and a
// reference model that lists the writes and the outcome of each load.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int unsigned MAXW = 8;
  localparam int unsigned RDL  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'h00;
  logic        restart  = 1'b0;
  logic        in_ready;
  logic [31:0] a2, wd2, rd2;
  logic [3:0]  we2;
  logic        core_rst, load_pass, load_err;
  state_t      dbg_state;
  logic [31:0] dbg_wr_sum;

  inst_loader #(.MAX_WORDS(MAXW), .RD_LATENCY(RDL)) dut (
    .CPU_CLK                 (clk),
    .CPU_RST_N               (rst_n),
    .in_valid                (in_valid),
    .in_data                 (in_data),
    .in_ready                (in_ready),
    .restart                 (restart),
    .CPU_Debug_InstCache_A2  (a2),
    .CPU_Debug_InstCache_WD2 (wd2),
    .CPU_Debug_InstCache_WE2 (we2),
    .CPU_Debug_InstCache_RD2 (rd2),
    .core_rst                (core_rst),
    .load_pass               (load_pass),
    .load_err                (load_err),
    .dbg_state               (dbg_state),
    .dbg_wr_sum              (dbg_wr_sum)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- cache model ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_pipe [RDL];
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;

  assign rd2 = rd_pipe[RDL-1];

  always @(posedge clk) begin : cache_model
    logic [31:0] v;
    v = mem.exists(a2) ? mem[a2] : 32'h0;
    if (corrupt_en && a2 == corrupt_addr) v = v ^ 32'h1;
    for (int k = RDL - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_pipe[0] <= v;
    if (we2 == 4'hF) mem[a2] = wd2;
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {address, data} of each expected write
  logic [31:0] obs_q[$];   // addresses actually written in this load

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare: every write must be the next expected one, and the
  // status outputs must be mutually consistent.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (core_rst !== !load_pass || (load_pass && load_err) ||
          (in_ready && (load_pass || load_err))) begin
        errors++;
        $display("FAIL status: core_rst=%b load_pass=%b load_err=%b in_ready=%b",
                 core_rst, load_pass, load_err, in_ready);
      end
      if (we2 !== 4'h0) begin
        logic [63:0] e;
        obs_q.push_back(a2);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got we=%h a=%h d=%h expected no write",
                   we2, a2, wd2);
        end else begin
          e = exp_q.pop_front();
          if ({we2, a2, wd2} !== {4'hF, e}) begin
            errors++;
            $display("FAIL write: got we=%h a=%h d=%h expected we=f a=%h d=%h",
                     we2, a2, wd2, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic build_stream(input logic [31:0] base, input logic [31:0] n,
                              input logic [31:0] w[$], output logic [7:0] s[$]);
    s.delete();
    for (int k = 0; k < 4; k++) s.push_back(base[8*k +: 8]);
    for (int k = 0; k < 4; k++) s.push_back(n[8*k +: 8]);
    foreach (w[i]) for (int k = 0; k < 4; k++) s.push_back(w[i][8*k +: 8]);
  endtask

  // Offer bytes with random gaps; a byte is consumed only when in_ready.
  task automatic send_bytes(input logic [7:0] s[$], input int gap_pct,
                            input bit rnd_restart);
    foreach (s[k]) begin
      int  waited;
      bit  taken;
      waited = 0;
      taken  = 0;
      while (!taken) begin
        @(negedge clk);
        in_valid = ($urandom_range(99) >= gap_pct);
        in_data  = in_valid ? s[k] : 8'($urandom);
        restart  = rnd_restart && ($urandom_range(7) == 0);
        if (in_valid && in_ready) taken = 1;
        else if (++waited > 300) begin
          check("byte_accept_timeout", 64'(k), 64'(s.size()));
          in_valid = 1'b0;
          restart  = 1'b0;
          return;
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    restart  = 1'b0;
  endtask

  // ---------------- reference model + one complete load ----------------
  task automatic run_load(input string name, input logic [31:0] base,
                          input logic [31:0] n, input logic [31:0] w[$],
                          input int corrupt_idx, input int gap_pct,
                          input bit rnd_restart);
    logic [7:0]  s[$];
    bit          exp_pass;
    logic [31:0] exp_sum;
    int          cyc;
    exp_pass = 1;
    exp_sum  = 32'h0;
    exp_q.delete();
    obs_q.delete();
    build_stream(base, n, w, s);
    if (base[1:0] != 2'b00) begin
      exp_pass = 0;
      while (s.size() > 4) void'(s.pop_back());
    end else if (n > MAXW || n == 0) begin
      exp_pass = (n == 0);
      while (s.size() > 8) void'(s.pop_back());
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back({base + 32'(4 * i), w[i]});
        exp_sum += w[i];
      end
      if (corrupt_idx >= 0 && corrupt_idx < int'(n)) begin
        corrupt_en   = 1'b1;
        corrupt_addr = base + 32'(4 * corrupt_idx);
        exp_pass     = 0;
      end
    end

    send_bytes(s, gap_pct, rnd_restart);

    cyc = 0;
    while (!(load_pass || load_err) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_finish_in_time"}, 64'(cyc < 3000), 64'(1));
    check({name, "_outcome"}, {60'h0, load_pass, load_err, core_rst, in_ready},
          {60'h0, exp_pass, !exp_pass, !exp_pass, 1'b0});
    check({name, "_wr_sum"}, 64'(dbg_wr_sum), 64'(exp_sum));
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'(0));

    // Restart from DONE/ERROR: back to HDR_ADDR with core held in reset.
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check({name, "_restart"}, {51'h0, core_rst, in_ready, load_pass, load_err,
                               dbg_state, dbg_wr_sum == 32'h0},
          {51'h0, 1'b1, 1'b1, 1'b0, 1'b0, HDR_ADDR, 1'b1});
    corrupt_en = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] wq[$];
    logic [7:0]  s[$];

    repeat (3) @(negedge clk);
    check("reset_outputs", {22'h0, in_ready, we2, core_rst, load_pass, load_err,
                            dbg_state, a2 == 32'h0, wd2 == 32'h0},
          {22'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, HDR_ADDR, 1'b1, 1'b1});
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word load at base 0 with hand-computed checksum.
    wq = '{32'h00000013, 32'hDEADBEEF};
    run_load("basic", 32'h0, 32'd2, wq, -1, 0, 0);
    check("basic_sum_literal", 64'(dbg_wr_sum), 64'(0));  // cleared by restart
    check("basic_write_count", 64'(obs_q.size()), 64'(2));
    if (obs_q.size() == 2)
      check("basic_addrs_literal", {obs_q[0], obs_q[1]}, {32'h0, 32'h4});

    // Same load again, pinning the checksum before restart clears it.
    exp_q.delete();
    obs_q.delete();
    exp_q.push_back({32'h0, 32'h00000013});
    exp_q.push_back({32'h4, 32'hDEADBEEF});
    build_stream(32'h0, 32'd2, wq, s);
    send_bytes(s, 30, 0);
    repeat (20) @(negedge clk);
    check("basic2_pass_literal", {62'h0, load_pass, core_rst}, {62'h0, 1'b1, 1'b0});
    check("basic2_sum_literal", 64'(dbg_wr_sum), 64'(32'hDEADBF02));
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_from_done", {61'h0, core_rst, dbg_state}, {61'h0, 1'b1, HDR_ADDR});

    // Header and size boundaries.
    wq.delete();
    run_load("misaligned", 32'h00000002, 32'd2, wq, -1, 20, 0);
    check("misaligned_no_write", 64'(obs_q.size()), 64'(0));
    run_load("too_many", 32'h0, 32'(MAXW + 1), wq, -1, 20, 0);
    run_load("zero_words", 32'h40, 32'd0, wq, -1, 20, 0);
    for (int i = 0; i < int'(MAXW); i++) wq.push_back($urandom);
    run_load("max_words", 32'h1000, 32'(MAXW), wq, -1, 10, 1);

    // Corrupted readback of word 1.
    wq = '{32'h00000013, 32'hDEADBEEF};
    run_load("corrupt", 32'h0, 32'd2, wq, 1, 0, 0);

    // Address wrap with gappy input and random restart pulses.
    wq = '{32'hCAFEF00D, 32'h12345678};
    run_load("wrap", 32'hFFFFFFFC, 32'd2, wq, -1, 60, 1);
    check("wrap_write_count", 64'(obs_q.size()), 64'(2));
    if (obs_q.size() == 2)
      check("wrap_addrs_literal", {obs_q[0], obs_q[1]}, {32'hFFFFFFFC, 32'h0});

    // Reset during DATA of word 1, then a clean reload.
    wq = '{32'h11111111, 32'h22222222, 32'h33333333};
    exp_q.delete();
    exp_q.push_back({32'h100, 32'h11111111});
    build_stream(32'h100, 32'd3, wq, s);
    while (s.size() > 14) void'(s.pop_back());
    send_bytes(s, 20, 0);
    check("pre_reset_writes", 64'(exp_q.size()), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {21'h0, in_ready, we2, core_rst, load_pass, load_err,
                          dbg_state, a2 == 32'h0, wd2 == 32'h0, dbg_wr_sum == 32'h0},
          {21'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, HDR_ADDR, 1'b1, 1'b1, 1'b1});
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_load("reload", 32'h100, 32'd3, wq, -1, 20, 1);

    // Random loads.
    for (int t = 0; t < 10; t++) begin
      logic [31:0] base;
      int          n;
      int          cidx;
      base = ($urandom_range(3) == 0) ? 32'hFFFFFFF0 : {$urandom, 2'b00} >> 0;
      base[1:0] = 2'b00;
      n = $urandom_range(MAXW, 1);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      cidx = ($urandom_range(3) == 0) ? $urandom_range(n - 1) : -1;
      run_load("random", base, 32'(n), wq, cidx, $urandom_range(60), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
